bp_fe_ras_ctrl: RTL and testbench
=================================

Name: bp_fe_ras_ctrl

Overview:
- Return-address-stack controller in the front end, directly upstream of the RAS storage stack.
- Consumes predecoded call/return information from fetch and drives the stack's push/pop/write-data.
- Registers the popped return target for the branch predictor.
- Tracks stack occupancy to suppress overflow and underflow, and realigns the stack pointer to 0 after a frontend redirect by draining with pops.

Parameters:
- vaddr_width_p, 16, width of PCs and stack entries; must equal the stack width.
- els_p, 8, stack depth; must equal the stack depth.
- instr_bytes_p, 4, byte size of a call instruction; the return address is pc + instr_bytes_p.
- cnt_width_lp, $clog2(els_p+1), occupancy counter width (derived).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- pd_v_i  in  1  predecode entry valid.
- pd_ready_o  out  1  controller accepts an entry; an entry is accepted when pd_v_i & pd_ready_o.
- pd_pc_i  in  vaddr_width_p  PC of the predecoded instruction.
- pd_is_call_i  in  1  instruction is a call.
- pd_is_ret_i  in  1  instruction is a return (both set = coroutine swap).
- redirect_i  in  1  frontend redirect/flush.
- push_o  out  1  stack push.
- pop_o  out  1  stack pop.
- w_data_o  out  vaddr_width_p  stack write data.
- r_data_i  in  vaddr_width_p  stack read data; valid in the same cycle as pop_o when push_o=0.
- ret_v_o  out  1  registered return-prediction valid (single-cycle pulse).
- ret_hit_o  out  1  ret_addr_o came from the stack (0 = underflow, no prediction).
- ret_addr_o  out  vaddr_width_p  predicted return target.
- count_o  out  cnt_width_lp  current occupancy.

Behaviour:
- **States:** RUN, SWAP, FLUSH.
- **Ready:** pd_ready_o = (state==RUN) & ~redirect_i.
- **Reset (async, reset_i=0):**
  - state=RUN, count=0, pending register=0.
  - ret_v_o=0, ret_hit_o=0, ret_addr_o=0.
  - Effect is immediate, mid-operation included; push_o and pop_o are forced to 0 while reset is asserted.
- **Write data:** w_data_o = (pd_pc_i + instr_bytes_p) mod 2^vaddr_width_p, or the pending register in SWAP.
- **push_o/pop_o:** combinational from the accept condition.
- **Return outputs:** ret_* are registered and appear 1 cycle after acceptance. ret_v_o is 0 in every other cycle; ret_hit_o and ret_addr_o hold their value when ret_v_o=0.
- **RUN, accepted entry:**
  - Call only, count<els_p: push_o=1; count+1.
  - Call only, count==els_p: push_o=0 (dropped); count unchanged.
  - Ret only, count>0: pop_o=1; capture r_data_i; next cycle ret_v_o=1, ret_hit_o=1, ret_addr_o=r_data_i; count-1.
  - Ret only, count==0: pop_o=0; next cycle ret_v_o=1, ret_hit_o=0, ret_addr_o=0.
  - Call+ret, count>0:
    - Cycle 1: pop_o=1 only; capture r_data_i; save pc+instr_bytes_p in the pending register; go to SWAP.
    - Next cycle: ret_v_o=1, ret_hit_o=1.
  - Call+ret, count==0: push only (as a call); ret_v_o=1, ret_hit_o=0 next cycle.
  - Neither flag: no stack action.
- **SWAP:**
  - push_o=1 with the pending data; go to RUN.
  - Net count is unchanged across the swap; the stack never sees push and pop together.
- **Redirect:**
  - redirect_i=1 takes priority. An entry presented the same cycle is not accepted, and no push/pop is issued that cycle.
  - A pending SWAP push is discarded.
  - Next state: FLUSH if count>0, else RUN.
- **FLUSH:**
  - pop_o=1 every cycle; count-1 per cycle; r_data_i ignored; ret_v_o=0.
  - When a pop takes count from 1 to 0, next state is RUN.
  - redirect_i during FLUSH: stay in FLUSH.
- **Invariants:**
  - count is never above els_p and never below 0.
  - push_o and pop_o are never both 1.
  - Stack pointer equals count at all times.

Test Plan:
1. Reset; calls at pc 0x0100, 0x0200, 0x0300; then ret -> push_o pulses ×3 with w_data_o 0x0104, 0x0204, 0x0304. On the ret: pop_o=1; next cycle ret_v_o=1, ret_hit_o=1, ret_addr_o=0x0304; count_o=2.
2. 8 calls then a 9th call at 0x0900 -> 9th cycle push_o=0, count_o stays 8. Then 8 rets return 0x0804 down to 0x0104, all ret_hit_o=1.
3. Ret with count 0 -> pop_o=0; next cycle ret_v_o=1, ret_hit_o=0, ret_addr_o=0; count_o=0.
4. Count 2 (top=0x0204); call+ret at pc 0x0500 ->
   - Cycle 0: pop_o=1, pd_ready_o=1.
   - Cycle 1: SWAP, pd_ready_o=0, push_o=1 with w_data_o=0x0504; ret_addr_o=0x0204, ret_hit_o=1.
   - count_o back to 2.
5. Count 3; redirect_i together with a valid call -> no push. Pop_o=1 for 3 consecutive cycles, pd_ready_o=0 throughout, count_o 3→0. Then RUN; a call at 0x0700 pushes 0x0704 and the next ret returns 0x0704.
6. reset_i low asynchronously in mid-FLUSH (count 2) and mid-SWAP -> without a clock edge: push_o=0, pop_o=0, count_o=0, ret_v_o=0. After release: RUN with pd_ready_o=1.

Source files
------------

// File: rtl/bp_fe_ras_ctrl.sv
// Return-address-stack controller: turns predecoded calls/returns into
// stack push/pop, registers return predictions and drains on redirect.
module bp_fe_ras_ctrl #(
    parameter int vaddr_width_p = 16,
    parameter int els_p         = 8,
    parameter int instr_bytes_p = 4,
    localparam int cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     pd_v_i,
    output logic                     pd_ready_o,
    input  logic [vaddr_width_p-1:0] pd_pc_i,
    input  logic                     pd_is_call_i,
    input  logic                     pd_is_ret_i,
    input  logic                     redirect_i,
    output logic                     push_o,
    output logic                     pop_o,
    output logic [vaddr_width_p-1:0] w_data_o,
    input  logic [vaddr_width_p-1:0] r_data_i,
    output logic                     ret_v_o,
    output logic                     ret_hit_o,
    output logic [vaddr_width_p-1:0] ret_addr_o,
    output logic [cnt_width_lp-1:0]  count_o
);

    typedef enum logic [1:0] {RUN, SWAP, FLUSH} state_e;

    localparam logic [cnt_width_lp-1:0] full_lp = cnt_width_lp'(els_p);

    state_e                   state_q, state_d;
    logic [cnt_width_lp-1:0]  count_q, count_d;
    logic [vaddr_width_p-1:0] pend_q, pend_d;
    logic                     ret_v_q, ret_v_d;
    logic                     ret_hit_q, ret_hit_d;
    logic [vaddr_width_p-1:0] ret_addr_q, ret_addr_d;
    logic [vaddr_width_p-1:0] ret_pc;
    logic                     accept, push, pop, nonempty;

    assign ret_pc     = pd_pc_i + vaddr_width_p'(instr_bytes_p);
    assign nonempty   = (count_q != '0);
    assign pd_ready_o = (state_q == RUN) & ~redirect_i;
    assign accept     = pd_v_i & pd_ready_o;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= RUN;
            count_q    <= '0;
            pend_q     <= '0;
            ret_v_q    <= 1'b0;
            ret_hit_q  <= 1'b0;
            ret_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            ret_v_q    <= ret_v_d;
            ret_hit_q  <= ret_hit_d;
            ret_addr_q <= ret_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (redirect_i)
                    state_d = nonempty ? FLUSH : RUN;
                else if (accept & pd_is_call_i & pd_is_ret_i & nonempty)
                    state_d = SWAP;
            end
            SWAP: begin
                if (redirect_i)
                    state_d = nonempty ? FLUSH : RUN;
                else
                    state_d = RUN;
            end
            FLUSH: begin
                if (count_q <= cnt_width_lp'(1))
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        count_d    = count_q;
        pend_d     = pend_q;
        ret_v_d    = 1'b0;
        ret_hit_d  = ret_hit_q;
        ret_addr_d = ret_addr_q;
        w_data_o   = ret_pc;
        unique case (state_q)
            RUN: begin
                if (accept) begin
                    if (pd_is_ret_i) begin
                        ret_v_d    = 1'b1;
                        ret_hit_d  = nonempty;
                        ret_addr_d = nonempty ? r_data_i : '0;
                    end
                    // A swap pops first; its push is deferred to SWAP
                    if (pd_is_ret_i & nonempty) begin
                        pop     = 1'b1;
                        count_d = count_q - 1'b1;
                        if (pd_is_call_i)
                            pend_d = ret_pc;
                    end else if (pd_is_call_i & (count_q != full_lp)) begin
                        push    = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end
            end
            SWAP: begin
                w_data_o = pend_q;
                if (!redirect_i) begin
                    push    = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            FLUSH: begin
                if (nonempty) begin
                    pop     = 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign push_o     = push & reset_i;
    assign pop_o      = pop & reset_i;
    assign ret_v_o    = ret_v_q;
    assign ret_hit_o  = ret_hit_q;
    assign ret_addr_o = ret_addr_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_bp_fe_ras_ctrl.sv
// Bench for bp_fe_ras_ctrl: stack memory environment, queue-based
// reference model, and a scoreboard monitor for return predictions.
module tb_bp_fe_ras_ctrl;

    localparam int W = 16;
    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pd_v_i, pd_ready_o, pd_is_call_i, pd_is_ret_i, redirect_i;
    logic [W-1:0]  pd_pc_i, w_data_o, r_data_i, ret_addr_o;
    logic          push_o, pop_o, ret_v_o, ret_hit_o;
    logic [3:0]    count_o;

    always #5 clk = ~clk;

    bp_fe_ras_ctrl #(.vaddr_width_p(W), .els_p(N), .instr_bytes_p(4)) dut (
        .clk_i(clk), .reset_i(rst_n),
        .pd_v_i(pd_v_i), .pd_ready_o(pd_ready_o), .pd_pc_i(pd_pc_i),
        .pd_is_call_i(pd_is_call_i), .pd_is_ret_i(pd_is_ret_i),
        .redirect_i(redirect_i), .push_o(push_o), .pop_o(pop_o),
        .w_data_o(w_data_o), .r_data_i(r_data_i), .ret_v_o(ret_v_o),
        .ret_hit_o(ret_hit_o), .ret_addr_o(ret_addr_o), .count_o(count_o)
    );

    // Stack storage the controller drives
    logic [W-1:0] mem [N];
    int           sp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp <= 0;
        else if (push_o && sp < N) begin
            mem[sp] <= w_data_o;
            sp <= sp + 1;
        end else if (pop_o && sp > 0) sp <= sp - 1;
    end

    always_comb begin
        r_data_i = 16'hdead;
        if (sp > 0) r_data_i = mem[sp-1];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: return addresses live in a plain queue
    typedef struct {
        bit           hit;
        logic [W-1:0] addr;
        int           due;
    } exp_t;

    typedef enum {M_RUN, M_SWAP, M_FLUSH} mode_e;

    exp_t         sb[$];
    logic [W-1:0] ras[$];
    mode_e        mst = M_RUN;
    int           flush_left = 0;
    logic [W-1:0] pend = '0;

    task automatic model_reset();
        ras.delete();
        sb.delete();
        mst = M_RUN;
        flush_left = 0;
    endtask

    task automatic expect_ret(input bit hit, input logic [W-1:0] a);
        exp_t e;
        e.hit = hit;
        e.addr = a;
        e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic start_flush();
        if (ras.size() > 0) begin
            flush_left = ras.size();
            ras.delete();
            mst = M_FLUSH;
        end else mst = M_RUN;
    endtask

    task automatic model_cycle();
        bit           e_push, e_pop, e_rdy;
        int           e_cnt;
        logic [W-1:0] e_wd, rpc;
        e_push = 0;
        e_pop = 0;
        rpc = pd_pc_i + 16'd4;
        e_cnt = (mst == M_FLUSH) ? flush_left : ras.size();
        e_rdy = (mst == M_RUN) && !redirect_i;
        e_wd = (mst == M_SWAP) ? pend : rpc;
        case (mst)
            M_RUN: begin
                if (redirect_i) start_flush();
                else if (pd_v_i) begin
                    if (pd_is_ret_i) begin
                        if (ras.size() > 0) begin
                            expect_ret(1'b1, ras.pop_back());
                            e_pop = 1;
                            if (pd_is_call_i) begin
                                pend = rpc;
                                mst = M_SWAP;
                            end
                        end else expect_ret(1'b0, '0);
                    end
                    if (pd_is_call_i && !e_pop && ras.size() < N) begin
                        e_push = 1;
                        ras.push_back(rpc);
                    end
                end
            end
            M_SWAP: begin
                if (redirect_i) start_flush();
                else begin
                    e_push = 1;
                    ras.push_back(pend);
                    mst = M_RUN;
                end
            end
            M_FLUSH: begin
                e_pop = 1;
                flush_left--;
                if (flush_left == 0) mst = M_RUN;
            end
            default: ;
        endcase
        chk("ready", 32'(pd_ready_o), 32'(e_rdy));
        chk("push", 32'(push_o), 32'(e_push));
        chk("pop", 32'(pop_o), 32'(e_pop));
        chk("count", 32'(count_o), 32'(e_cnt));
        if (e_push) chk("w_data", 32'(w_data_o), 32'(e_wd));
    endtask

    // Monitor: consumes expected predictions when the DUT presents one
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("push_pop_excl", 32'(push_o & pop_o), 32'h0);
                chk("sp_eq_count", 32'(count_o), 32'(sp));
                if (ret_v_o) begin
                    if (sb.size() == 0) begin
                        chk("ret_unexpected", 32'(ret_v_o), 32'h0);
                    end else begin
                        e = sb.pop_front();
                        chk("ret_cycle", 32'(cyc), 32'(e.due));
                        chk("ret_hit", 32'(ret_hit_o), 32'(e.hit));
                        chk("ret_addr", 32'(ret_addr_o), 32'(e.addr));
                    end
                end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    chk("ret_missing", 32'(ret_v_o), 32'h1);
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [W-1:0] pc,
                         input bit call, input bit ret, input bit redir);
        pd_v_i = v;
        pd_pc_i = pc;
        pd_is_call_i = call;
        pd_is_ret_i = ret;
        redirect_i = redir;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_push", 32'(push_o), 32'h0);
        chk("arst_pop", 32'(pop_o), 32'h0);
        chk("arst_count", 32'(count_o), 32'h0);
        chk("arst_ret_v", 32'(ret_v_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_ready", 32'(pd_ready_o), 32'h1);
    endtask

    initial begin
        rst_n = 1'b0;
        pd_v_i = 1'b1;
        pd_pc_i = 16'h0100;
        pd_is_call_i = 1'b1;
        pd_is_ret_i = 1'b0;
        redirect_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_push", 32'(push_o), 32'h0);
        chk("rst_pop", 32'(pop_o), 32'h0);
        chk("rst_count", 32'(count_o), 32'h0);
        chk("rst_ret_v", 32'(ret_v_o), 32'h0);
        chk("rst_ret_hit", 32'(ret_hit_o), 32'h0);
        chk("rst_ret_addr", 32'(ret_addr_o), 32'h0);
        pd_v_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three calls then a return
        drive(1, 16'h0100, 1, 0, 0);
        drive(1, 16'h0200, 1, 0, 0);
        drive(1, 16'h0300, 1, 0, 0);
        drive(1, 16'h0000, 0, 1, 0);
        idle(1);
        chk("t1_count", 32'(count_o), 32'h2);
        drive(1, 16'h0000, 0, 1, 0);
        drive(1, 16'h0000, 0, 1, 0);

        // Fill to capacity, overflow, drain
        for (int i = 1; i <= 9; i++) drive(1, 16'(i * 256), 1, 0, 0);
        chk("t2_full", 32'(count_o), 32'h8);
        for (int i = 0; i < 8; i++) drive(1, '0, 0, 1, 0);

        // Underflow
        drive(1, 16'h0000, 0, 1, 0);
        idle(1);
        chk("t3_count", 32'(count_o), 32'h0);

        // Coroutine swap
        drive(1, 16'h0100, 1, 0, 0);
        drive(1, 16'h0200, 1, 0, 0);
        drive(1, 16'h0500, 1, 1, 0);
        idle(2);
        chk("t4_count", 32'(count_o), 32'h2);
        drive(1, '0, 0, 1, 0);
        drive(1, '0, 0, 1, 0);

        // Redirect drain then reuse
        for (int i = 1; i <= 3; i++) drive(1, 16'(i * 256), 1, 0, 0);
        drive(1, 16'h0400, 1, 0, 1);
        idle(3);
        chk("t5_count", 32'(count_o), 32'h0);
        drive(1, 16'h0700, 1, 0, 0);
        drive(1, 16'h0000, 0, 1, 0);
        idle(1);

        // Asynchronous reset mid-FLUSH
        for (int i = 1; i <= 3; i++) drive(1, 16'(i * 256), 1, 0, 0);
        drive(0, '0, 0, 0, 1);
        idle(1);
        chk("t6_flush_cnt", 32'(count_o), 32'h2);
        chk("t6_flush_pop", 32'(pop_o), 32'h1);
        pulse_reset();

        // Asynchronous reset mid-SWAP
        drive(1, 16'h0100, 1, 0, 0);
        drive(1, 16'h0200, 1, 0, 0);
        drive(1, 16'h0500, 1, 1, 0);
        pd_v_i = 1'b0;
        pd_is_call_i = 1'b0;
        pd_is_ret_i = 1'b0;
        #1;
        chk("t6_swap_push", 32'(push_o), 32'h1);
        pulse_reset();

        // Randomized traffic, call-heavy first then balanced
        for (int i = 0; i < 3000; i++) begin
            int  c;
            bit  call, ret;
            c = (i < 800) ? 60 : 35;
            call = ($urandom_range(99) < c);
            ret = ($urandom_range(99) < 35);
            drive($urandom_range(99) < 75,
                  16'($urandom) & 16'hfffc, call, ret,
                  $urandom_range(99) < 4);
        end
        idle(N + 3);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
